dtw_stream_feeder: RTL and testbench
====================================

Name: dtw_stream_feeder

Overview:
- Upstream sequencer for one DTW core datapath instance.
- Accepts a query squiggle stream and a reference word stream (valid/ready) and buffers the query locally.
- Drives the core's rst/running/Input_squiggle/Rword/ref_len inputs with the exact per-cycle timing the core expects, stalling the core while reference data is late.
- Captures the core's minval/position into a result handshake.

Parameters:
- width, 16, sample/word width; must match the core.
- SQG_SIZE, 250, query length; must match the core.
- PAD_WORD, 0, Rword value driven once the reference is exhausted.
- DRAIN_CYC, 2, cycles waited after core done before result capture.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  job start pulse; honoured only in IDLE
- ref_len  in  32  reference word count; latched on accepted start
- q_valid / q_ready  in / out  1 / 1  query handshake
- q_data  in  width  query sample
- r_valid / r_ready  in / out  1 / 1  reference handshake
- r_data  in  width  reference word
- core_rst  out  1  reset to core
- core_running  out  1  running to core
- core_squiggle  out  width  Input_squiggle to core
- core_rword  out  width  Rword to core
- core_ref_len  out  32  ref_len to core
- core_done  in  1  done from core
- core_minval  in  width  minval from core
- core_position  in  32  position from core
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_minval  out  width  captured minimum
- res_position  out  32  captured position
- res_err  out  1  job rejected (ref_len == 0)
- busy  out  1  state != IDLE

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All state is in a single clk domain.
- Reset values:
  - State = IDLE, all counters 0, query buffer contents don't-care.
  - res_valid=0, res_minval=all-ones, res_position=0, res_err=0, busy=0.
  - q_ready=0, r_ready=0, core_running=0.
  - core_rst=1 while rst is high; core_rst = rst | (state==CLEAR).
- IDLE:
  - start with ref_len!=0: latch ref_len into len_r, go to CLEAR.
  - start with ref_len==0: set res_err=1, go to RESULT without touching the core.
  - start is ignored outside IDLE.
- CLEAR: lasts 1 cycle with core_rst=1, then go to LOAD_Q.
- LOAD_Q:
  - q_ready=1. Each q handshake writes qbuf[q_cnt] and increments q_cnt.
  - When the handshake with q_cnt==SQG_SIZE-1 completes, go to RUN with q_cnt=0.
  - r_ready=0 throughout.
- RUN (run-cycle index n counts cycles with core_running=1, starting at 0):
  - n=0 is the priming cycle: core_running=1 unconditionally, nothing consumed, set primed.
  - After priming, core_running = !core_done && (ref_cnt>=len_r || r_valid).
  - r_ready = primed && !core_done && ref_cnt<len_r. A handshake increments ref_cnt.
  - core_rword = r_data while ref_cnt<len_r, else PAD_WORD.
  - core_squiggle = qbuf[sq_idx]. sq_idx increments on each primed running cycle while sq_idx<SQG_SIZE-1, then holds.
  - core_done high (primed): core_running=0, go to DRAIN.
  - Required totals: exactly len_r+SQG_SIZE+1 running cycles, exactly len_r reference handshakes, exactly SQG_SIZE pad cycles.
  - Stalls (r_valid=0, ref not exhausted) deassert core_running with no state advance. Stalls are legal anywhere in RUN, including the squiggle-load window.
- DRAIN: core_running=0 for DRAIN_CYC cycles, then capture core_minval/core_position into res_*, res_err=0, go to RESULT.
- RESULT:
  - res_valid=1 and res_* held stable until res_ready.
  - On the handshake, go to IDLE; res_valid drops the next cycle.
  - res_ready high on the first RESULT cycle completes in 1 cycle.
- Combinational outputs: core_running, core_rword, r_ready, q_ready are decoded from state/counters with zero latency. No combinational path from r_valid to r_ready.
- rst mid-job: immediate return to IDLE, core held in reset, any partial result discarded.

Test Plan:
- SQG_SIZE=4, query {5,5,5,5}, ref_len=8 all 5, no stalls -> res_minval=0; 13 core_running cycles; 8 r handshakes; 4 PAD cycles; res_err=0.
- Same job with r_valid toggling 1-0-1-0 -> identical res_minval/res_position. core_running low exactly on r_valid=0 cycles inside the ref phase; total running cycles still 13.
- start with ref_len=0 -> no core_rst pulse, no core_running; res_valid=1 next-next cycle with res_err=1 and res_minval=all-ones.
- Query stream with gaps (q_valid 1 in 3) -> RUN entered only after the 4th q handshake; r_ready=0 before that; qbuf order preserved (core_squiggle sequence 1,2,3,4 for query 1,2,3,4).
- Hold res_ready=0 for 10 cycles -> res_* stable and busy=1; start pulses ignored; release -> IDLE next cycle.
- Assert rst during RUN (after 3 ref words) -> core_rst=1, state IDLE, res_valid=0; a following full job produces the same result as a clean run.

Source files
------------

// File: rtl/dtw_stream_feeder.sv
// Upstream sequencer for one DTW core: buffers the query, streams the reference
// with per-cycle stall control, and hands the core's minimum back over a result handshake.
module dtw_stream_feeder #(
    parameter int               width     = 16,
    parameter int               SQG_SIZE  = 250,
    parameter logic [width-1:0] PAD_WORD  = '0,
    parameter int               DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ref_len,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [width-1:0] q_data,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [width-1:0] r_data,
    output logic             core_rst,
    output logic             core_running,
    output logic [width-1:0] core_squiggle,
    output logic [width-1:0] core_rword,
    output logic [31:0]      core_ref_len,
    input  logic             core_done,
    input  logic [width-1:0] core_minval,
    input  logic [31:0]      core_position,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [width-1:0] res_minval,
    output logic [31:0]      res_position,
    output logic             res_err,
    output logic             busy
);

    localparam int              QW         = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;
    localparam logic [QW-1:0]   Q_LAST     = QW'(SQG_SIZE - 1);
    localparam logic [31:0]     PAD_TOTAL  = 32'(SQG_SIZE);
    localparam logic [31:0]     DRAIN_LAST = (DRAIN_CYC > 0) ? 32'(DRAIN_CYC - 1) : 32'd0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD_Q = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      len_q, len_d;
    logic [QW-1:0]    q_cnt_q, q_cnt_d;
    logic [QW-1:0]    sq_idx_q, sq_idx_d;
    logic [31:0]      ref_cnt_q, ref_cnt_d;
    logic [31:0]      pad_cnt_q, pad_cnt_d;
    logic [31:0]      drain_cnt_q, drain_cnt_d;
    logic             primed_q, primed_d;
    logic [width-1:0] res_minval_q, res_minval_d;
    logic [31:0]      res_position_q, res_position_d;
    logic             res_err_q, res_err_d;
    logic [width-1:0] qbuf_q [SQG_SIZE];

    logic in_run;
    logic ref_left;
    logic pad_done;
    logic q_hs;
    logic r_hs;
    logic run_adv;

    assign in_run   = (state_q == S_RUN);
    assign ref_left = (ref_cnt_q < len_q);
    assign pad_done = (pad_cnt_q >= PAD_TOTAL);

    // Priming cycle runs unconditionally; afterwards the core only advances when
    // the reference word it needs is present (or the reference is exhausted).
    // The pad cap keeps the running total exact even if done arrives late.
    always_comb begin
        core_running = 1'b0;
        if (in_run) begin
            if (!primed_q) begin
                core_running = 1'b1;
            end else begin
                core_running = !core_done && !pad_done && (!ref_left || r_valid);
            end
        end
    end

    assign r_ready       = in_run && primed_q && !core_done && ref_left;
    assign q_ready       = (state_q == S_LOAD_Q);
    assign q_hs          = q_ready && q_valid;
    assign r_hs          = r_ready && r_valid;
    assign run_adv       = in_run && primed_q && core_running;
    assign core_rst      = rst || (state_q == S_CLEAR);
    assign core_rword    = ref_left ? r_data : PAD_WORD;
    assign core_squiggle = qbuf_q[sq_idx_q];
    assign core_ref_len  = len_q;
    assign res_valid     = (state_q == S_RESULT);
    assign res_minval    = res_minval_q;
    assign res_position  = res_position_q;
    assign res_err       = res_err_q;
    assign busy          = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        q_cnt_d        = q_cnt_q;
        sq_idx_d       = sq_idx_q;
        ref_cnt_d      = ref_cnt_q;
        pad_cnt_d      = pad_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        primed_d       = primed_q;
        res_minval_d   = res_minval_q;
        res_position_d = res_position_q;
        res_err_d      = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_cnt_d     = '0;
                    sq_idx_d    = '0;
                    ref_cnt_d   = '0;
                    pad_cnt_d   = '0;
                    drain_cnt_d = '0;
                    primed_d    = 1'b0;
                    if (ref_len != 32'd0) begin
                        len_d   = ref_len;
                        state_d = S_CLEAR;
                    end else begin
                        res_err_d      = 1'b1;
                        res_minval_d   = '1;
                        res_position_d = '0;
                        state_d        = S_RESULT;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_LOAD_Q;
            end
            S_LOAD_Q: begin
                if (q_hs) begin
                    if (q_cnt_q == Q_LAST) begin
                        q_cnt_d = '0;
                        state_d = S_RUN;
                    end else begin
                        q_cnt_d = q_cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!primed_q) begin
                    primed_d = 1'b1;
                end else if (core_done) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    if (r_hs) begin
                        ref_cnt_d = ref_cnt_q + 32'd1;
                    end
                    if (run_adv && !ref_left) begin
                        pad_cnt_d = pad_cnt_q + 32'd1;
                    end
                    if (run_adv && (sq_idx_q != Q_LAST)) begin
                        sq_idx_d = sq_idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q >= DRAIN_LAST) begin
                    res_minval_d   = core_minval;
                    res_position_d = core_position;
                    res_err_d      = 1'b0;
                    state_d        = S_RESULT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            q_cnt_q        <= '0;
            sq_idx_q       <= '0;
            ref_cnt_q      <= '0;
            pad_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            primed_q       <= 1'b0;
            res_minval_q   <= '1;
            res_position_q <= '0;
            res_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            q_cnt_q        <= q_cnt_d;
            sq_idx_q       <= sq_idx_d;
            ref_cnt_q      <= ref_cnt_d;
            pad_cnt_q      <= pad_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            primed_q       <= primed_d;
            res_minval_q   <= res_minval_d;
            res_position_q <= res_position_d;
            res_err_q      <= res_err_d;
        end
    end

    // Query buffer has no reset: contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (q_hs) begin
            qbuf_q[q_cnt_q] <= q_data;
        end
    end

endmodule

// File: tb/tb_dtw_stream_feeder.sv
// Directed bench for dtw_stream_feeder with a small behavioural DTW-core stand-in
// whose result depends on every word and squiggle it is fed while running.
module tb_dtw_stream_feeder;

   localparam int W   = 16;
   localparam int SQG = 4;

   logic          clk = 1'b0;
   logic          rst, start, q_valid, r_valid, res_ready;
   logic [31:0]   ref_len;
   logic [W-1:0]  q_data, r_data;
   logic          q_ready, r_ready, core_rst, core_running, res_valid, res_err, busy;
   logic [W-1:0]  core_squiggle, core_rword, core_minval, res_minval;
   logic [31:0]   core_ref_len, core_position, res_position;
   logic          core_done;

   int compared = 0;
   int mismatched = 0;

   dtw_stream_feeder #(.width(W), .SQG_SIZE(SQG), .PAD_WORD('0), .DRAIN_CYC(2)) dut (
      .clk(clk), .rst(rst), .start(start), .ref_len(ref_len),
      .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .core_rst(core_rst), .core_running(core_running),
      .core_squiggle(core_squiggle), .core_rword(core_rword), .core_ref_len(core_ref_len),
      .core_done(core_done), .core_minval(core_minval), .core_position(core_position),
      .res_valid(res_valid), .res_ready(res_ready), .res_minval(res_minval),
      .res_position(res_position), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Core stand-in: counts running cycles, accumulates |rword - squiggle| over the
   // reference phase, and raises done after ref_len + SQG + 1 running cycles.
   logic [31:0] cRun, cAcc, cDiff;
   logic        cDone;
   assign cDiff         = (core_rword > core_squiggle) ? 32'(core_rword - core_squiggle)
                                                       : 32'(core_squiggle - core_rword);
   assign core_done     = cDone;
   assign core_minval   = cAcc[W-1:0];
   assign core_position = cRun;

   always @(posedge clk) begin
      if (core_rst) begin
         cRun  <= 0;
         cAcc  <= 0;
         cDone <= 1'b0;
      end else if (core_running && !cDone) begin
         cRun <= cRun + 1;
         if (cRun >= 1 && cRun <= core_ref_len) cAcc <= cAcc + cDiff;
         if (cRun + 1 == core_ref_len + SQG + 1) cDone <= 1'b1;
      end
   end

   // Per-job monitor, sampled on the falling edge; a new jobId clears it.
   int          jobId = 0, seenJob = 0;
   int          curLen = 0;
   int          runCyc, rHs, qHs, padCyc, stallViol, rReadyEarly, runEarly, rstSeen;
   bit          primedSeen;
   logic [W-1:0] sqSeq[$];

   always @(negedge clk) begin
      if (jobId != seenJob) begin
         seenJob = jobId;
         runCyc = 0; rHs = 0; qHs = 0; padCyc = 0; stallViol = 0;
         rReadyEarly = 0; runEarly = 0; rstSeen = 0; primedSeen = 0;
         sqSeq.delete();
      end
      if (core_rst && !rst) rstSeen++;
      if (r_ready && qHs < SQG) rReadyEarly++;
      if (primedSeen && rHs < curLen && !core_done && (core_running != r_valid)) stallViol++;
      if (core_running) begin
         runCyc++;
         if (qHs < SQG) runEarly++;
         if (!primedSeen) begin
            primedSeen = 1;
         end else begin
            sqSeq.push_back(core_squiggle);
            if (rHs >= curLen && core_rword == '0) padCyc++;
         end
      end
      if (q_valid && q_ready) qHs++;
      if (r_valid && r_ready) rHs++;
   end

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [W-1:0] qv [SQG];
   logic [W-1:0] refVal;

   task automatic startPulse(input logic [31:0] len);
      ref_len = len;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic feedQuery(input bit gap);
      bit hs;
      for (int i = 0; i < SQG; i++) begin
         if (gap) begin
            q_valid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
         end
         q_valid = 1'b1;
         q_data  = qv[i];
         hs = 0;
         for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk); hs = q_ready;
            @(posedge clk); #1;
         end
         checkOutput("q_handshake", 32'(hs), 32'd1);
         q_valid = 1'b0;
      end
   endtask

   task automatic feedRef(input int words, input bit stall);
      bit hs;
      bit phase = 1'b1;
      for (int i = 0; i < words; i++) begin
         hs = 0;
         for (int t = 0; t < 500 && !hs; t++) begin
            r_valid = stall ? phase : 1'b1;
            r_data  = r_valid ? refVal : 16'd99;
            @(negedge clk); hs = r_valid && r_ready;
            @(posedge clk); #1;
            phase = ~phase;
         end
         checkOutput("r_handshake", 32'(hs), 32'd1);
      end
      r_valid = 1'b0;
      r_data  = 16'd99;
   endtask

   task automatic waitResult();
      bit seen = 0;
      for (int t = 0; t < 1000 && !seen; t++) begin
         @(negedge clk);
         seen = res_valid;
      end
      checkOutput("res_valid_seen", 32'(seen), 32'd1);
   endtask

   task automatic acceptResult();
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_accept", 32'(busy), 32'd0);
      checkOutput("res_valid_dropped", 32'(res_valid), 32'd0);
   endtask

   task automatic applyStimulus(input int len, input int refWords, input bit stall, input bit gap);
      jobId++;
      curLen = len;
      @(posedge clk); #1;
      startPulse(32'(len));
      fork
         feedQuery(gap);
         feedRef(refWords, stall);
      join
   endtask

   initial begin
      int bad;
      rst = 1'b1; start = 1'b0; ref_len = 0; q_valid = 1'b0; q_data = 0;
      r_valid = 1'b0; r_data = 16'd99; res_ready = 1'b0; refVal = 16'd5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_minval", 32'(res_minval), 32'hFFFF);
      checkOutput("rst_res_position", res_position, 32'd0);
      checkOutput("rst_res_err", 32'(res_err), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_q_ready", 32'(q_ready), 32'd0);
      checkOutput("rst_r_ready", 32'(r_ready), 32'd0);
      checkOutput("rst_core_running", 32'(core_running), 32'd0);
      checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Clean job: all-5 query against all-5 reference.
      for (int i = 0; i < SQG; i++) qv[i] = 16'd5;
      applyStimulus(8, 8, 1'b0, 1'b0);
      waitResult();
      checkOutput("A_minval", 32'(res_minval), 32'd0);
      checkOutput("A_position", res_position, 32'd13);
      checkOutput("A_err", 32'(res_err), 32'd0);
      checkOutput("A_run_cycles", 32'(runCyc), 32'd13);
      checkOutput("A_r_handshakes", 32'(rHs), 32'd8);
      checkOutput("A_pad_cycles", 32'(padCyc), 32'd4);
      checkOutput("A_core_ref_len", core_ref_len, 32'd8);

      // Result held back: outputs must stay put and a start pulse must be ignored.
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         start   = (c == 3);
         ref_len = 0;
         @(negedge clk);
         if (res_valid !== 1'b1 || res_minval !== 16'd0 || res_position !== 32'd13 ||
             res_err !== 1'b0 || busy !== 1'b1) bad++;
      end
      start = 1'b0;
      checkOutput("hold_unstable_cycles", 32'(bad), 32'd0);
      acceptResult();
      checkOutput("hold_err_after", 32'(res_err), 32'd0);

      // Same job with the reference stream stalling every other cycle.
      applyStimulus(8, 8, 1'b1, 1'b0);
      waitResult();
      checkOutput("B_minval", 32'(res_minval), 32'd0);
      checkOutput("B_position", res_position, 32'd13);
      checkOutput("B_run_cycles", 32'(runCyc), 32'd13);
      checkOutput("B_r_handshakes", 32'(rHs), 32'd8);
      checkOutput("B_pad_cycles", 32'(padCyc), 32'd4);
      checkOutput("B_stall_tracking", 32'(stallViol), 32'd0);
      acceptResult();

      // Zero-length reference: rejected without touching the core.
      jobId++;
      curLen = 0;
      @(posedge clk); #1;
      startPulse(32'd0);
      bad = 0;
      for (int t = 0; t < 2 && !bad; t++) begin
         @(negedge clk);
         bad = res_valid ? 1 : 0;
      end
      checkOutput("Z_res_valid", 32'(bad), 32'd1);
      checkOutput("Z_err", 32'(res_err), 32'd1);
      checkOutput("Z_minval", 32'(res_minval), 32'hFFFF);
      checkOutput("Z_position", res_position, 32'd0);
      checkOutput("Z_core_rst_pulses", 32'(rstSeen), 32'd0);
      checkOutput("Z_run_cycles", 32'(runCyc), 32'd0);
      acceptResult();

      // Sparse query stream: order preserved, no reference pulled before the load ends.
      qv[0] = 16'd1; qv[1] = 16'd2; qv[2] = 16'd3; qv[3] = 16'd4;
      applyStimulus(2, 2, 1'b0, 1'b1);
      waitResult();
      checkOutput("G_run_early", 32'(runEarly), 32'd0);
      checkOutput("G_r_ready_early", 32'(rReadyEarly), 32'd0);
      checkOutput("G_sq_count", 32'(sqSeq.size()), 32'd6);
      for (int i = 0; i < SQG; i++) begin
         logic [W-1:0] got;
         got = (sqSeq.size() > i) ? sqSeq[i] : 16'hDEAD;
         checkOutput($sformatf("G_squiggle_%0d", i), 32'(got), 32'(i + 1));
      end
      checkOutput("G_minval", 32'(res_minval), 32'd7);
      checkOutput("G_position", res_position, 32'd7);
      acceptResult();

      // Reset in the middle of RUN, then a clean rerun of the first job.
      for (int i = 0; i < SQG; i++) qv[i] = 16'd5;
      applyStimulus(8, 3, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("R_core_rst", 32'(core_rst), 32'd1);
      checkOutput("R_core_running", 32'(core_running), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("R_busy", 32'(busy), 32'd0);
      checkOutput("R_res_valid", 32'(res_valid), 32'd0);
      checkOutput("R_r_ready", 32'(r_ready), 32'd0);
      applyStimulus(8, 8, 1'b0, 1'b0);
      waitResult();
      checkOutput("R2_minval", 32'(res_minval), 32'd0);
      checkOutput("R2_position", res_position, 32'd13);
      checkOutput("R2_run_cycles", 32'(runCyc), 32'd13);
      checkOutput("R2_err", 32'(res_err), 32'd0);
      acceptResult();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
